// File: rtl/idecoder_stage_if.sv
// Handshake and decoded-field bundle between the decode stage and its
// producer/consumer. The stage itself attaches through the slave modport.
interface idecoder_stage_if #(
   parameter int INST_WIDTH      = 32,
   parameter int IMM_WIDTH       = 32,
   parameter int REG_WIDTH       = 5,
   parameter int FUNCT_WIDTH     = 4,
   parameter int INST_TYPE_WIDTH = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [INST_WIDTH-1:0]      inst;
   logic                       out_valid;
   logic                       out_ready;
   logic [6:0]                 opcode;
   logic [INST_TYPE_WIDTH-1:0] inst_type;
   logic [IMM_WIDTH-1:0]       imm;
   logic [REG_WIDTH-1:0]       rd;
   logic [REG_WIDTH-1:0]       rs1;
   logic [REG_WIDTH-1:0]       rs2;
   logic [FUNCT_WIDTH-1:0]     funct;
   logic                       illegal;

   modport master (
      output in_valid, inst, out_ready,
      input  in_ready, out_valid, opcode, inst_type, imm, rd, rs1, rs2, funct, illegal
   );

   modport slave (
      input  in_valid, inst, out_ready,
      output in_ready, out_valid, opcode, inst_type, imm, rd, rs1, rs2, funct, illegal
   );
endinterface

// File: rtl/idecoder_stage.sv
// RV32I-style instruction decode stage: decodes the incoming word and
// pushes the decoded fields into a small FIFO whose head drives the outputs.
module idecoder_stage #(
   parameter int INST_WIDTH      = 32,
   parameter int IMM_WIDTH       = 32,
   parameter int REG_WIDTH       = 5,
   parameter int FUNCT_WIDTH     = 4,
   parameter int INST_TYPE_WIDTH = 4,
   parameter int DEPTH           = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   idecoder_stage_if.slave   bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_INT_IMM = 7'b0010011;
   localparam logic [6:0] OP_INT_REG = 7'b0110011;

   localparam logic [INST_TYPE_WIDTH-1:0] T_LUI     = INST_TYPE_WIDTH'(0);
   localparam logic [INST_TYPE_WIDTH-1:0] T_INT_IMM = INST_TYPE_WIDTH'(1);
   localparam logic [INST_TYPE_WIDTH-1:0] T_INT_REG = INST_TYPE_WIDTH'(2);
   localparam logic [INST_TYPE_WIDTH-1:0] T_BRANCH  = INST_TYPE_WIDTH'(3);
   localparam logic [INST_TYPE_WIDTH-1:0] T_AUIPC   = INST_TYPE_WIDTH'(4);
   localparam logic [INST_TYPE_WIDTH-1:0] T_JAL     = INST_TYPE_WIDTH'(5);
   localparam logic [INST_TYPE_WIDTH-1:0] T_JALR    = INST_TYPE_WIDTH'(6);
   localparam logic [INST_TYPE_WIDTH-1:0] T_LOAD    = INST_TYPE_WIDTH'(7);
   localparam logic [INST_TYPE_WIDTH-1:0] T_STORE   = INST_TYPE_WIDTH'(8);
   localparam logic [INST_TYPE_WIDTH-1:0] T_ILLEGAL = INST_TYPE_WIDTH'(15);

   typedef struct packed {
      logic [6:0]                 opcode;
      logic [INST_TYPE_WIDTH-1:0] inst_type;
      logic [IMM_WIDTH-1:0]       imm;
      logic [REG_WIDTH-1:0]       rd;
      logic [REG_WIDTH-1:0]       rs1;
      logic [REG_WIDTH-1:0]       rs2;
      logic [FUNCT_WIDTH-1:0]     funct;
      logic                       illegal;
   } entry_t;

   entry_t                dec;
   entry_t                mem_q [DEPTH];
   entry_t                head;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        count_q, count_d;
   logic                  full, not_empty, push, pop;

   logic [31:0]           iw;
   logic [2:0]            f3;
   logic [REG_WIDTH-1:0]  f_rd, f_rs1, f_rs2;
   logic [IMM_WIDTH-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

   assign iw    = bus.inst[31:0];
   assign f3    = iw[14:12];
   assign f_rd  = REG_WIDTH'(iw[11:7]);
   assign f_rs1 = REG_WIDTH'(iw[19:15]);
   assign f_rs2 = REG_WIDTH'(iw[24:20]);

   assign imm_i = IMM_WIDTH'($signed(iw[31:20]));
   assign imm_s = IMM_WIDTH'($signed({iw[31:25], iw[11:7]}));
   assign imm_b = IMM_WIDTH'($signed({iw[31], iw[7], iw[30:25], iw[11:8], 1'b0}));
   assign imm_u = IMM_WIDTH'($signed({iw[31:12], 12'b0}));
   assign imm_j = IMM_WIDTH'($signed({iw[31], iw[19:12], iw[20], iw[30:21], 1'b0}));

   // Decode the incoming instruction into one queue entry
   always_comb begin
      dec           = '0;
      dec.opcode    = iw[6:0];
      dec.inst_type = T_ILLEGAL;
      dec.illegal   = 1'b1;
      if (iw[1:0] == 2'b11) begin
         dec.illegal = 1'b0;
         case (iw[6:0])
            OP_LUI:     begin dec.inst_type = T_LUI;   dec.imm = imm_u; dec.rd = f_rd; end
            OP_AUIPC:   begin dec.inst_type = T_AUIPC; dec.imm = imm_u; dec.rd = f_rd; end
            OP_JAL:     begin dec.inst_type = T_JAL;   dec.imm = imm_j; dec.rd = f_rd; end
            OP_JALR: begin
               dec.inst_type = T_JALR;  dec.imm = imm_i; dec.rd = f_rd; dec.rs1 = f_rs1;
               dec.funct     = FUNCT_WIDTH'({1'b0, f3});
            end
            OP_BRANCH: begin
               dec.inst_type = T_BRANCH; dec.imm = imm_b; dec.rs1 = f_rs1; dec.rs2 = f_rs2;
               dec.funct     = FUNCT_WIDTH'({1'b0, f3});
            end
            OP_LOAD: begin
               dec.inst_type = T_LOAD;  dec.imm = imm_i; dec.rd = f_rd; dec.rs1 = f_rs1;
               dec.funct     = FUNCT_WIDTH'({1'b0, f3});
            end
            OP_STORE: begin
               dec.inst_type = T_STORE; dec.imm = imm_s; dec.rs1 = f_rs1; dec.rs2 = f_rs2;
               dec.funct     = FUNCT_WIDTH'({1'b0, f3});
            end
            OP_INT_IMM: begin
               dec.inst_type = T_INT_IMM; dec.imm = imm_i; dec.rd = f_rd; dec.rs1 = f_rs1;
               // Shift-right immediates carry the arithmetic/logical select in bit 30
               dec.funct     = (f3 == 3'b101) ? FUNCT_WIDTH'({iw[30], f3})
                                              : FUNCT_WIDTH'({1'b0, f3});
            end
            OP_INT_REG: begin
               dec.inst_type = T_INT_REG; dec.rd = f_rd; dec.rs1 = f_rs1; dec.rs2 = f_rs2;
               dec.funct     = FUNCT_WIDTH'({iw[31:25] == 7'b0100000, f3});
            end
            default: begin
               dec.inst_type = T_ILLEGAL;
               dec.illegal   = 1'b1;
            end
         endcase
      end
   end

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign not_empty = (count_q != '0);
   assign push      = bus.in_valid && !full && !flush;
   assign pop       = not_empty && bus.out_ready && !flush;

   // Next-state pointer and occupancy; flush discards everything including a same-cycle push
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Queue control state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observable through the valid-gated head
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= dec;
   end

   assign head          = not_empty ? mem_q[rd_ptr_q] : '0;
   assign bus.in_ready  = !full;
   assign bus.out_valid = not_empty;
   assign bus.opcode    = head.opcode;
   assign bus.inst_type = head.inst_type;
   assign bus.imm       = head.imm;
   assign bus.rd        = head.rd;
   assign bus.rs1       = head.rs1;
   assign bus.rs2       = head.rs2;
   assign bus.funct     = head.funct;
   assign bus.illegal   = head.illegal;
endmodule

// File: doc/idecoder_stage.md
IDECODER_STAGE -- requirements
Module: idecoder_stage

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter IMM_WIDTH, default 32, immediate width; SHALL be at least 21.
REQ-003 SHALL have parameter REG_WIDTH, default 5, register index width.
REQ-004 SHALL have parameter FUNCT_WIDTH, default 4, funct field width.
REQ-005 SHALL have parameter INST_TYPE_WIDTH, default 4, instruction class width.
REQ-006 SHALL have parameter DEPTH, default 2, output queue entries; SHALL be a power of two and at least 2.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 flush  input  1  synchronous queue clear.
REQ-010 in_valid  input  1  inst is valid.
REQ-011 in_ready  output  1  stage accepts inst this cycle.
REQ-012 inst  input  INST_WIDTH  raw instruction.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  consumer takes head entry.
REQ-015 opcode  output  7  inst[6:0] of head entry.
REQ-016 inst_type, imm, rd, rs1, rs2, funct  output  widths as parameters  decoded fields of head entry.
REQ-017 illegal  output  1  head entry is an unsupported encoding.

Function
REQ-018 inst_type encoding SHALL be: 0 LUI, 1 INT_IMM, 2 INT_REG, 3 BRANCH, 4 AUIPC, 5 JAL, 6 JALR, 7 LOAD, 8 STORE, 15 ILLEGAL.
REQ-019 Opcodes SHALL be 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 INT_IMM, 0110011 INT_REG.
REQ-020 Immediates SHALL be sign-extended from inst[31] to IMM_WIDTH: U = {inst[31:12], 12'b0}; I = inst[31:20]; S = {inst[31:25], inst[11:7]}; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}; J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-021 rd SHALL be inst[11:7] for LUI, AUIPC, JAL, JALR, LOAD, INT_IMM and INT_REG; else 0.
REQ-022 rs1 SHALL be inst[19:15] for JALR, BRANCH, LOAD, STORE, INT_IMM and INT_REG; else 0.
REQ-023 rs2 SHALL be inst[24:20] for BRANCH, STORE and INT_REG; else 0.
REQ-024 funct SHALL be {0, inst[14:12]} for JALR, BRANCH, LOAD, STORE and INT_IMM, except INT_IMM with inst[14:12]=101, which SHALL be {inst[30], 101}.
REQ-025 For INT_REG, funct SHALL be {inst[31:25]==0100000, inst[14:12]}; unused fields SHALL be 0.
REQ-026 Any opcode not listed, or inst[1:0]!=11, SHALL give illegal=1, inst_type=15, and imm, rd, rs1, rs2 and funct all 0; opcode SHALL still be reported.
REQ-027 Decode SHALL be registered: an inst accepted in cycle N (in_valid&&in_ready) SHALL appear at the head with out_valid=1 no earlier than cycle N+1, and exactly N+1 if the queue was empty.
REQ-028 The queue SHALL hold up to DEPTH decoded entries in FIFO order.
REQ-029 in_ready SHALL equal !full, with no combinational path from out_ready.
REQ-030 A pop SHALL occur when out_valid&&out_ready.
REQ-031 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-032 Pointers SHALL wrap modulo DEPTH.
REQ-033 While out_valid=1 and out_ready=0, all head outputs SHALL be held stable.
REQ-034 When out_valid=0, all decoded outputs SHALL be 0.
REQ-035 flush=1 SHALL empty the queue at the next edge and discard any same-cycle push; out_valid=0 and in_ready=1 on the following cycle.

Reset
REQ-036 On rst=0, asynchronously and regardless of in-flight handshakes: the queue SHALL empty, out_valid=0, in_ready=1 and all decoded outputs 0.
REQ-037 The first accept SHALL occur on the first rising edge with rst=1 and in_valid=1.

Verification
REQ-038 Scenario: inst=0x123450B7 accepted, out_ready=1 -> next cycle inst_type=0, rd=1, imm=0x12345000, illegal=0.
REQ-039 Scenario: 0xFFF00093 then 0x402081B3 back-to-back -> first entry: type 1, rd=1, rs1=0, imm=0xFFFFFFFF, funct=0; second entry: type 2, rd=3, rs1=1, rs2=2, funct=4'b1000.
REQ-040 Scenario: inst=0xFE000EE3 -> type 3, imm=0xFFFFFFFC, rs1=0, rs2=0, rd=0, funct=0.
REQ-041 Scenario: DEPTH=2, out_ready=0, three pushes offered -> in_ready=0 after the second accept, third held off; raise out_ready -> outputs in order, no loss or duplication.
REQ-042 Scenario: inst=0x0000007F -> illegal=1, type=15, opcode=0x7F, other fields 0.
REQ-043 Scenario: queue holding 2 entries, assert flush with a push in the same cycle, then separately pulse rst=0 mid-burst -> each time out_valid=0 and in_ready=1, with no stale entries emitted afterwards.
